// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory/IO bus controller: size codes, FSM states,
// the I/O region tag and the request-size to byte-beat mapping.
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_B  = 2'd0;
    localparam logic [1:0] SZ_H  = 2'd1;
    localparam logic [1:0] SZ_W  = 2'd2;
    localparam logic [1:0] IO_HI = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_IO_WAIT,
        ST_DONE
    } state_e;

    // Size code 3 is illegal and is handled as a word.
    function automatic logic [2:0] size_to_beats(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Two-way round-robin arbiter between instruction fetch (bit 0) and the
// load/store buffer (bit 1); rr_q remembers who was granted last.
module mem_ctrl_arb (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant
);

    logic rr_q;
    logic rr_d;

    always_comb begin
        grant = 2'b00;
        rr_d  = rr_q;
        if (grant_en) begin
            if (req == 2'b11) begin
                grant = rr_q ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
            if (|req) begin
                rr_d = grant[1];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory/IO bus sequencer for IF and LSB requests.
// Optional MEM_CTRL_IO_FULL_EN holds I/O write beats while the UART buffer is full.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int IO_ADDR_MSB = 17
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_data,
    input  logic              lsb_req,
    input  logic              lsb_we,
    input  logic [1:0]        lsb_size,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [31:0]       lsb_wdata,
    output logic              lsb_ack,
    output logic [31:0]       lsb_rdata
);

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [2:0]          nb_q, nb_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                owner_q, owner_d;
    logic                abort_ok_q, abort_ok_d;
    logic [31:0]         data_q, data_d;
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic [7:0]          mem_dout_q, mem_dout_d;
    logic                mem_wr_q, mem_wr_d;

    logic [1:0]          grant;
    logic                grant_en;
    logic                acc_lsb;
    logic [ADDR_W-1:0]   acc_addr;
    logic [ADDR_W-1:0]   next_addr;
    logic [1:0]          lane;
    logic                abort;
    logic                io_stall;

    function automatic logic is_io(input logic [ADDR_W-1:0] a);
        return a[IO_ADDR_MSB -: 2] == IO_HI;
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    assign grant_en = rdy_in && (state_q == ST_IDLE) && !clear;

    mem_ctrl_arb u_arb (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .req      ({lsb_req, if_req}),
        .grant_en (grant_en),
        .grant    (grant)
    );

    assign acc_lsb   = grant[1];
    assign acc_addr  = acc_lsb ? lsb_addr : if_addr;
    assign next_addr = base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
    assign lane      = cnt_q[1:0] - 2'd1;
    // An abortable transfer is one whose bus reads have no side effects.
    assign abort     = clear && abort_ok_q;

`ifdef MEM_CTRL_IO_FULL_EN
    logic [ADDR_W-1:0] beat_addr;
    assign beat_addr = (state_q == ST_IDLE) ? acc_addr : next_addr;
    assign io_stall  = is_io(beat_addr) && io_buffer_full;
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
    assign io_stall       = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nb_d       = nb_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        owner_d    = owner_q;
        abort_ok_d = abort_ok_q;
        data_d     = data_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_ack     = 1'b0;
        lsb_ack    = 1'b0;

        if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (|grant) begin
                        base_d     = acc_addr;
                        mem_a_d    = acc_addr;
                        owner_d    = acc_lsb;
                        wdata_d    = lsb_wdata;
                        cnt_d      = 3'd0;
                        data_d     = 32'd0;
                        nb_d       = acc_lsb ? size_to_beats(lsb_size) : 3'd4;
                        abort_ok_d = !acc_lsb || (!lsb_we && !is_io(acc_addr));
                        if (acc_lsb && lsb_we) begin
                            mem_dout_d = lsb_wdata[7:0];
                            mem_wr_d   = !io_stall;
                            state_d    = io_stall ? ST_IO_WAIT : ST_WRITE;
                        end else begin
                            state_d = ST_READ;
                        end
                    end
                end
                // Reads overlap: address k+1 goes out while byte k is in flight.
                ST_READ: begin
                    if (abort) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (cnt_q + 3'd1 < nb_q) begin
                            mem_a_d = next_addr;
                        end
                        if (cnt_q != 3'd0) begin
                            for (int i = 0; i < 4; i++) begin
                                if (lane == 2'(i)) begin
                                    data_d[8*i +: 8] = mem_din;
                                end
                            end
                        end
                        if (cnt_q == nb_q) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (cnt_q + 3'd1 < nb_q) begin
                        mem_a_d    = next_addr;
                        mem_dout_d = byte_sel(wdata_q, cnt_q[1:0] + 2'd1);
                        cnt_d      = cnt_q + 3'd1;
                        mem_wr_d   = !io_stall;
                        if (io_stall) begin
                            state_d = ST_IO_WAIT;
                        end
                    end else begin
                        mem_wr_d = 1'b0;
                        state_d  = ST_DONE;
                    end
                end
`ifdef MEM_CTRL_IO_FULL_EN
                ST_IO_WAIT: begin
                    if (!io_buffer_full) begin
                        mem_wr_d = 1'b1;
                        state_d  = ST_WRITE;
                    end
                end
`endif
                ST_DONE: begin
                    if (!abort) begin
                        if_ack  = !owner_q;
                        lsb_ack = owner_q;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            nb_q       <= 3'd0;
            base_q     <= '0;
            wdata_q    <= 32'd0;
            owner_q    <= 1'b0;
            abort_ok_q <= 1'b0;
            data_q     <= 32'd0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nb_q       <= nb_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            owner_q    <= owner_d;
            abort_ok_q <= abort_ok_d;
            data_q     <= data_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q && rdy_in;
    assign if_data   = data_q;
    assign lsb_rdata = data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed requests push expected acks and bus
// writes; an independent monitor pops and compares them as the DUT presents them.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req, if_ack;
    logic [31:0] if_addr, if_data;
    logic        lsb_req, lsb_we, lsb_ack;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;

    int cyc = 0;
    int total = 0;
    int passed = 0;

    typedef struct {
        bit          is_lsb;
        bit          chk_data;
        logic [31:0] data;
        int          cyc;
    } ack_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    ack_t ack_q[$];
    wr_t  wr_q[$];

    bit [7:0] mem [0:4095];

    mem_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .clear          (clear),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_ack         (if_ack),
        .if_data        (if_data),
        .lsb_req        (lsb_req),
        .lsb_we         (lsb_we),
        .lsb_size       (lsb_size),
        .lsb_addr       (lsb_addr),
        .lsb_wdata      (lsb_wdata),
        .lsb_ack        (lsb_ack),
        .lsb_rdata      (lsb_rdata)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Synchronous one-cycle RAM; it shares the rdy_in pause with the core.
    always @(posedge clk_in) begin
        if (rdy_in) mem_din <= mem[mem_a[11:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    // Monitor samples one time unit before each rising edge.
    always @(negedge clk_in) begin
        ack_t e;
        wr_t  w;
        #4;
        if (!rst_in) begin
            if (if_ack || lsb_ack) begin
                if (ack_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_ack: if_ack=%0b lsb_ack=%0b at cycle %0d, none required",
                             if_ack, lsb_ack, cyc);
                end else begin
                    e = ack_q.pop_front();
                    chk("ack_owner_is_lsb", 32'(lsb_ack), 32'(e.is_lsb));
                    chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.chk_data) chk("ack_data", e.is_lsb ? lsb_rdata : if_data, e.data);
                end
            end
            if (mem_wr) begin
                if (wr_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_write: addr %h data %h at cycle %0d, none required",
                             mem_a, mem_dout, cyc);
                end else begin
                    w = wr_q.pop_front();
                    chk("write_addr", mem_a, w.addr);
                    chk("write_data", {24'd0, mem_dout}, {24'd0, w.data});
                    chk("write_cycle", 32'(cyc), 32'(w.cyc));
                end
            end
        end
    end

    task automatic wait_ack(input bit lsb, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (lsb ? lsb_ack : if_ack) begin
                got = 1'b1;
                break;
            end
        end
        chk({nm, "_ack_seen"}, 32'(got), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d/%0d so far", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0;
        lsb_req = 1'b0; lsb_we = 1'b0; lsb_size = 2'd0; lsb_addr = '0; lsb_wdata = '0;
        {mem[12'h100], mem[12'h101], mem[12'h102], mem[12'h103]} = {8'h13, 8'h05, 8'h00, 8'h00};
        {mem[12'h104], mem[12'h105], mem[12'h106], mem[12'h107]} = {8'h93, 8'h00, 8'h10, 8'h00};
        {mem[12'h300], mem[12'h301], mem[12'h302], mem[12'h303]} = {8'h78, 8'h56, 8'h34, 8'h12};
        {mem[12'h310], mem[12'h311]} = {8'hCD, 8'hAB};
        {mem[12'h040], mem[12'h041], mem[12'h042], mem[12'h043]} = {8'h11, 8'h22, 8'h33, 8'h44};
        mem[12'h050] = 8'h5A;
        mem[12'h051] = 8'hA5;
        {mem[12'h010], mem[12'h011]} = {8'h34, 8'h82};

        repeat (3) @(negedge clk_in);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_if_ack", 32'(if_ack), 32'd0);
        chk("rst_lsb_ack", 32'(lsb_ack), 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_lsb_rdata", lsb_rdata, 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        // Contention straight after reset: LSB first, then IF on the next contention.
        c = cyc;
        ack_q.push_back('{1'b1, 1'b1, 32'h12345678, c + 6});
        if_req = 1'b1; if_addr = 32'h104;
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'd2; lsb_addr = 32'h300;
        wait_ack(1'b1, "t3_lsb_first");
        lsb_req = 1'b0;
        @(negedge clk_in);
        c = cyc;
        ack_q.push_back('{1'b0, 1'b1, 32'h00100093, c + 6});
        ack_q.push_back('{1'b1, 1'b1, 32'h0000ABCD, c + 11});
        lsb_req = 1'b1; lsb_size = 2'd1; lsb_addr = 32'h310;
        wait_ack(1'b0, "t3_if_second");
        if_req = 1'b0;
        wait_ack(1'b1, "t3_lsb_third");
        lsb_req = 1'b0;
        @(negedge clk_in);

        // Word fetch: ack five cycles after acceptance.
        c = cyc;
        ack_q.push_back('{1'b0, 1'b1, 32'h00000513, c + 6});
        if_req = 1'b1; if_addr = 32'h100;
        wait_ack(1'b0, "t1_fetch");
        if_req = 1'b0;
        @(negedge clk_in);

        // Word store: one byte per cycle, low byte first.
        c = cyc;
        lsb_wdata = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++)
            wr_q.push_back('{32'h200 + 32'(k), lsb_wdata[8*k +: 8], c + 1 + k});
        ack_q.push_back('{1'b1, 1'b0, 32'd0, c + 5});
        lsb_req = 1'b1; lsb_we = 1'b1; lsb_size = 2'd2; lsb_addr = 32'h200;
        wait_ack(1'b1, "t2_store");
        lsb_req = 1'b0; lsb_we = 1'b0;
        @(negedge clk_in);

        // Fetch aborted by clear while byte 2 is on the bus; pending load follows.
        c = cyc;
        if_req = 1'b1; if_addr = 32'h40;
        @(negedge clk_in);
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h50;
        @(negedge clk_in);
        @(negedge clk_in);
        ack_q.push_back('{1'b1, 1'b1, 32'h0000005A, c + 7});
        clear = 1'b1; if_req = 1'b0;
        @(negedge clk_in);
        clear = 1'b0;
        wait_ack(1'b1, "t4_after_clear");
        lsb_req = 1'b0;
        @(negedge clk_in);

        // clear in IDLE blocks acceptance for that edge only.
        c = cyc;
        ack_q.push_back('{1'b1, 1'b1, 32'h000000A5, c + 4});
        clear = 1'b1;
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h51;
        @(negedge clk_in);
        clear = 1'b0;
        wait_ack(1'b1, "t4b_clear_idle");
        lsb_req = 1'b0;
        @(negedge clk_in);

        // UART store while the tx buffer is full for three cycles.
        c = cyc;
`ifdef MEM_CTRL_IO_FULL_EN
        wr_q.push_back('{32'h00030000, 8'h41, c + 4});
        ack_q.push_back('{1'b1, 1'b0, 32'd0, c + 5});
`else
        wr_q.push_back('{32'h00030000, 8'h41, c + 1});
        ack_q.push_back('{1'b1, 1'b0, 32'd0, c + 2});
`endif
        io_buffer_full = 1'b1;
        lsb_req = 1'b1; lsb_we = 1'b1; lsb_size = 2'd0; lsb_addr = 32'h00030000; lsb_wdata = 32'h41;
        fork
            begin
                repeat (3) @(negedge clk_in);
                io_buffer_full = 1'b0;
            end
        join_none
        wait_ack(1'b1, "t5_io_store");
        lsb_req = 1'b0; lsb_we = 1'b0;
        repeat (4) @(negedge clk_in);

        // Halfword load paused for four cycles after its first edge.
        c = cyc;
        ack_q.push_back('{1'b1, 1'b1, 32'h00008234, c + 8});
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'd1; lsb_addr = 32'h10;
        @(negedge clk_in);
        @(negedge clk_in);
        rdy_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("t6_mem_a_frozen", mem_a, 32'h11);
        @(negedge clk_in);
        @(negedge clk_in);
        rdy_in = 1'b1;
        wait_ack(1'b1, "t6_paused_load");
        lsb_req = 1'b0;

        repeat (3) @(negedge clk_in);
        chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        chk("write_queue_drained", 32'(wr_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
